// File: rtl/thermal_governor_mz.sv
// Multi-zone thermal governor: EMA, dwell/hysteresis FSM, sticky CRIT.
// Optional trend detector: define THERMAL_GOV_TREND_EN.
module thermal_governor_mz #(
  parameter int NUM_ZONES = 4,
  parameter int TEMP_W    = 12,
  parameter int AVG_SHIFT = 3,
  parameter int DWELL     = 4,
  parameter int HYST      = 200,
  localparam int ZW = (NUM_ZONES > 1) ? $clog2(NUM_ZONES) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_ZONES*TEMP_W-1:0] temp_in,
  input  logic [NUM_ZONES-1:0]        temp_valid,
  input  logic [TEMP_W-1:0]           thr_warm,
  input  logic [TEMP_W-1:0]           thr_hot,
  input  logic [TEMP_W-1:0]           thr_crit,
  input  logic                        om_pulse,
  input  logic                        emerg_clear,
  output logic [2*NUM_ZONES-1:0]      zone_state,
  output logic [NUM_ZONES-1:0]        waveguide_en,
  output logic [NUM_ZONES-1:0]        throttle,
  output logic [NUM_ZONES-1:0]        emergency,
  output logic                        any_emergency,
  output logic [ZW-1:0]               hottest_zone,
  output logic [TEMP_W-1:0]           hottest_temp,
  output logic [NUM_ZONES-1:0]        trend_up
);

  localparam int CW = $clog2(DWELL + 1);
  localparam logic [CW-1:0] DW = CW'(DWELL);
  localparam logic [TEMP_W:0] HYST_V = (TEMP_W+1)'(HYST);

  typedef enum logic [1:0] {
    COOL = 2'd0,
    WARM = 2'd1,
    HOT  = 2'd2,
    CRIT = 2'd3
  } zstate_t;

  logic [TEMP_W-1:0]      avg_q  [NUM_ZONES];
  logic [NUM_ZONES-1:0]   primed_q;
  logic [NUM_ZONES-1:0]   upd_q;
  zstate_t                st_q   [NUM_ZONES];
  logic [CW-1:0]          up_q   [NUM_ZONES];
  logic [CW-1:0]          dn_q   [NUM_ZONES];

  logic [TEMP_W-1:0]      samp   [NUM_ZONES];
  logic signed [TEMP_W:0] diff   [NUM_ZONES];
  logic signed [TEMP_W:0] step   [NUM_ZONES];
  logic signed [TEMP_W+1:0] sum  [NUM_ZONES];
  logic [TEMP_W-1:0]      ema    [NUM_ZONES];
  logic [TEMP_W-1:0]      avg_d  [NUM_ZONES];

  zstate_t                st_d   [NUM_ZONES];
  logic [CW-1:0]          up_d   [NUM_ZONES];
  logic [CW-1:0]          dn_d   [NUM_ZONES];
  logic [NUM_ZONES-1:0]   up_hit;
  logic [NUM_ZONES-1:0]   dn_hit;
  logic [NUM_ZONES-1:0]   up_go;
  logic [NUM_ZONES-1:0]   dn_go;

  logic [TEMP_W:0]        wext;
  logic [TEMP_W:0]        hext;
  logic [TEMP_W-1:0]      warm_lo;
  logic [TEMP_W-1:0]      hot_lo;

  logic [TEMP_W-1:0]      cand   [NUM_ZONES];
  logic [TEMP_W-1:0]      best_t;
  logic [ZW-1:0]          best_z;

`ifdef THERMAL_GOV_TREND_EN
  logic [NUM_ZONES-1:0]   rise_d;
  logic [NUM_ZONES-1:0]   rise_q;
  logic [1:0]             run_q  [NUM_ZONES];
  logic [1:0]             run_d  [NUM_ZONES];
`endif

  // de-escalation edges, saturating at zero
  always_comb begin
    wext = {1'b0, thr_warm};
    hext = {1'b0, thr_hot};
    warm_lo = (wext > HYST_V) ? TEMP_W'(wext - HYST_V) : '0;
    hot_lo  = (hext > HYST_V) ? TEMP_W'(hext - HYST_V) : '0;
  end

  // EMA step with clamp; raw load when unprimed or resyncing
  always_comb begin
    for (int z = 0; z < NUM_ZONES; z++) begin
      samp[z] = temp_in[z*TEMP_W +: TEMP_W];
      diff[z] = $signed({1'b0, samp[z]}) - $signed({1'b0, avg_q[z]});
      step[z] = diff[z] >>> AVG_SHIFT;
      sum[z]  = $signed({2'b00, avg_q[z]})
              + $signed({step[z][TEMP_W], step[z]});
      if (sum[z][TEMP_W+1])
        ema[z] = '0;
      else if (sum[z][TEMP_W])
        ema[z] = '1;
      else
        ema[z] = sum[z][TEMP_W-1:0];
      if (om_pulse || !primed_q[z])
        avg_d[z] = samp[z];
      else
        avg_d[z] = ema[z];
`ifdef THERMAL_GOV_TREND_EN
      rise_d[z] = temp_valid[z] && primed_q[z] && !om_pulse
                && (ema[z] > avg_q[z]);
`endif
    end
  end

  // averages, primed flags and the update strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int z = 0; z < NUM_ZONES; z++) avg_q[z] <= '0;
      primed_q <= '0;
      upd_q    <= '0;
`ifdef THERMAL_GOV_TREND_EN
      rise_q   <= '0;
`endif
    end else begin
      for (int z = 0; z < NUM_ZONES; z++)
        if (temp_valid[z]) avg_q[z] <= avg_d[z];
      primed_q <= temp_valid | (om_pulse ? '0 : primed_q);
      upd_q    <= temp_valid;
`ifdef THERMAL_GOV_TREND_EN
      rise_q   <= rise_d;
`endif
    end
  end

  // per-zone next state: dwell, hysteresis, sticky CRIT
  always_comb begin
    for (int z = 0; z < NUM_ZONES; z++) begin
      st_d[z] = st_q[z];
      up_d[z] = up_q[z];
      dn_d[z] = dn_q[z];
      up_hit[z] = 1'b0;
      dn_hit[z] = 1'b0;
      up_go[z]  = 1'b0;
      dn_go[z]  = 1'b0;
`ifdef THERMAL_GOV_TREND_EN
      run_d[z] = run_q[z];
      if (upd_q[z])
        run_d[z] = !rise_q[z] ? 2'd0 :
                   (run_q[z] == 2'd3) ? 2'd3 : run_q[z] + 2'd1;
      if (om_pulse) run_d[z] = 2'd0;
`endif
      unique case (1'b1)
        (st_q[z] == COOL): up_hit[z] = avg_q[z] >= thr_warm;
        (st_q[z] == WARM): begin
          up_hit[z] = avg_q[z] >= thr_hot;
          dn_hit[z] = avg_q[z] < warm_lo;
        end
        (st_q[z] == HOT):  dn_hit[z] = avg_q[z] < hot_lo;
        (st_q[z] == CRIT): ;
      endcase
      if (upd_q[z]) begin
        up_d[z] = !up_hit[z] ? '0 :
                  (up_q[z] == DW) ? DW : up_q[z] + 1'b1;
        dn_d[z] = !dn_hit[z] ? '0 :
                  (dn_q[z] == DW) ? DW : dn_q[z] + 1'b1;
        up_go[z] = up_hit[z] && (up_d[z] == DW);
`ifdef THERMAL_GOV_TREND_EN
        if (up_hit[z] && st_q[z] == WARM && run_d[z] == 2'd3)
          up_go[z] = 1'b1;
`endif
        dn_go[z] = dn_hit[z] && (dn_d[z] == DW);
        if (up_go[z])
          st_d[z] = (st_q[z] == COOL) ? WARM : HOT;
        else if (dn_go[z])
          st_d[z] = (st_q[z] == HOT) ? WARM : COOL;
      end
      if (st_q[z] == CRIT && emerg_clear && avg_q[z] < thr_hot)
        st_d[z] = HOT;
      if (upd_q[z] && avg_q[z] >= thr_crit)
        st_d[z] = CRIT;
      if (st_d[z] != st_q[z] || om_pulse) begin
        up_d[z] = '0;
        dn_d[z] = '0;
      end
    end
  end

  // zone state and dwell counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int z = 0; z < NUM_ZONES; z++) begin
        st_q[z] <= COOL;
        up_q[z] <= '0;
        dn_q[z] <= '0;
`ifdef THERMAL_GOV_TREND_EN
        run_q[z] <= 2'd0;
`endif
      end
    end else begin
      for (int z = 0; z < NUM_ZONES; z++) begin
        st_q[z] <= st_d[z];
        up_q[z] <= up_d[z];
        dn_q[z] <= dn_d[z];
`ifdef THERMAL_GOV_TREND_EN
        run_q[z] <= run_d[z];
`endif
      end
    end
  end

  // hottest primed average, ties to the lowest index
  always_comb begin
    best_t = '0;
    best_z = '0;
    for (int z = 0; z < NUM_ZONES; z++) begin
      cand[z] = primed_q[z] ? avg_q[z] : '0;
      if (cand[z] > best_t) begin
        best_t = cand[z];
        best_z = ZW'(z);
      end
    end
  end

  // hottest-zone register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hottest_zone <= '0;
      hottest_temp <= '0;
    end else begin
      hottest_zone <= best_z;
      hottest_temp <= best_t;
    end
  end

  // decode registered state onto the zone outputs
  always_comb begin
    zone_state   = '0;
    waveguide_en = '0;
    throttle     = '0;
    emergency    = '0;
    trend_up     = '0;
    for (int z = 0; z < NUM_ZONES; z++) begin
      zone_state[2*z +: 2] = st_q[z];
      waveguide_en[z] = st_q[z] != COOL;
      throttle[z]     = (st_q[z] == HOT) || (st_q[z] == CRIT);
      emergency[z]    = st_q[z] == CRIT;
`ifdef THERMAL_GOV_TREND_EN
      trend_up[z]     = run_q[z] == 2'd3;
`endif
    end
  end

  assign any_emergency = |emergency;

endmodule

// File: tb/tb_thermal_governor_mz.sv
// Directed bench for thermal_governor_mz (4 zones, 12-bit).
// Expected averages are hand-computed EMA values.
module tb_thermal_governor_mz;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [47:0] temp_in = '0;
  logic [3:0]  temp_valid = '0;
  logic [11:0] thr_warm = 12'd2000;
  logic [11:0] thr_hot = 12'd3500;
  logic [11:0] thr_crit = 12'd4000;
  logic        om_pulse = 1'b0;
  logic        emerg_clear = 1'b0;
  logic [7:0]  zone_state;
  logic [3:0]  waveguide_en;
  logic [3:0]  throttle;
  logic [3:0]  emergency;
  logic        any_emergency;
  logic [1:0]  hottest_zone;
  logic [11:0] hottest_temp;
  logic [3:0]  trend_up;

  int checks = 0;
  int failures = 0;

  thermal_governor_mz dut (
    .clk(clk), .rst_n(rst_n),
    .temp_in(temp_in), .temp_valid(temp_valid),
    .thr_warm(thr_warm), .thr_hot(thr_hot), .thr_crit(thr_crit),
    .om_pulse(om_pulse), .emerg_clear(emerg_clear),
    .zone_state(zone_state), .waveguide_en(waveguide_en),
    .throttle(throttle), .emergency(emergency),
    .any_emergency(any_emergency),
    .hottest_zone(hottest_zone), .hottest_temp(hottest_temp),
    .trend_up(trend_up)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    temp_valid = '0;
    om_pulse = 1'b0;
    emerg_clear = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic send(input int z, input logic [11:0] v, input logic om);
    @(negedge clk);
    temp_in[z*12 +: 12] = v;
    temp_valid[z] = 1'b1;
    om_pulse = om;
    @(negedge clk);
    temp_valid = '0;
    om_pulse = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    emerg_clear = 1'b1;
    @(negedge clk);
    emerg_clear = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (zone_state !== 8'h00) begin
      failures++;
      $display("FAIL rst_state got=%h exp=00", zone_state);
    end
    checks++;
    if ({waveguide_en, throttle, emergency, trend_up} !== 16'h0) begin
      failures++;
      $display("FAIL rst_vec got=%h exp=0000",
               {waveguide_en, throttle, emergency, trend_up});
    end
    checks++;
    if ({any_emergency, hottest_zone, hottest_temp} !== 15'h0) begin
      failures++;
      $display("FAIL rst_hot got=%h exp=0",
               {any_emergency, hottest_zone, hottest_temp});
    end
  endtask

  task automatic test_warm_entry();
    send(0, 12'd3000, 1'b0);
    checks++;
    if (hottest_temp !== 12'd3000 || hottest_zone !== 2'd0) begin
      failures++;
      $display("FAIL first_avg got=%0d/%0d exp=3000/0",
               hottest_temp, hottest_zone);
    end
    repeat (2) send(0, 12'd3000, 1'b0);
    checks++;
    if (zone_state[1:0] !== 2'd0) begin
      failures++;
      $display("FAIL warm_3upd got=%0d exp=0", zone_state[1:0]);
    end
    send(0, 12'd3000, 1'b0);
    checks++;
    if (zone_state[1:0] !== 2'd1 || waveguide_en !== 4'b0001) begin
      failures++;
      $display("FAIL warm_4upd got=%0d/%b exp=1/0001",
               zone_state[1:0], waveguide_en);
    end
  endtask

  task automatic test_dwell();
    repeat (13) send(0, 12'd3600, 1'b0);
    checks++;
    if (zone_state[1:0] !== 2'd1 || hottest_temp !== 12'd3491) begin
      failures++;
      $display("FAIL ramp13 got=%0d/%0d exp=1/3491",
               zone_state[1:0], hottest_temp);
    end
`ifdef THERMAL_GOV_TREND_EN
    send(0, 12'd3600, 1'b0);
    checks++;
    if (zone_state[1:0] !== 2'd2 || hottest_temp !== 12'd3504) begin
      failures++;
      $display("FAIL trend_hot got=%0d/%0d exp=2/3504",
               zone_state[1:0], hottest_temp);
    end
`else
    repeat (2) send(0, 12'd3600, 1'b0);
    checks++;
    if (zone_state[1:0] !== 2'd1 || hottest_temp !== 12'd3516) begin
      failures++;
      $display("FAIL ramp15 got=%0d/%0d exp=1/3516",
               zone_state[1:0], hottest_temp);
    end
    send(0, 12'd3300, 1'b0);
    checks++;
    if (zone_state[1:0] !== 2'd1 || hottest_temp !== 12'd3489) begin
      failures++;
      $display("FAIL dip got=%0d/%0d exp=1/3489",
               zone_state[1:0], hottest_temp);
    end
    repeat (3) send(0, 12'd3600, 1'b0);
    checks++;
    if (zone_state[1:0] !== 2'd1 || hottest_temp !== 12'd3524) begin
      failures++;
      $display("FAIL restart3 got=%0d/%0d exp=1/3524",
               zone_state[1:0], hottest_temp);
    end
    send(0, 12'd3600, 1'b0);
    checks++;
    if (zone_state[1:0] !== 2'd2 || throttle !== 4'b0001 ||
        hottest_temp !== 12'd3533) begin
      failures++;
      $display("FAIL hot4 got=%0d/%b/%0d exp=2/0001/3533",
               zone_state[1:0], throttle, hottest_temp);
    end
`endif
  endtask

  task automatic test_crit();
    repeat (8) send(2, 12'd3700, 1'b0);
    checks++;
    if (zone_state[5:4] !== 2'd2) begin
      failures++;
      $display("FAIL z2_hot got=%0d exp=2", zone_state[5:4]);
    end
    send(2, 12'd4095, 1'b1);
    checks++;
    if (zone_state[5:4] !== 2'd3 || emergency !== 4'b0100 ||
        any_emergency !== 1'b1) begin
      failures++;
      $display("FAIL crit_in got=%0d/%b/%b exp=3/0100/1",
               zone_state[5:4], emergency, any_emergency);
    end
    checks++;
    if (hottest_zone !== 2'd2 || hottest_temp !== 12'd4095) begin
      failures++;
      $display("FAIL crit_hot got=%0d/%0d exp=2/4095",
               hottest_zone, hottest_temp);
    end
    send(2, 12'd3600, 1'b1);
    pulse_clear();
    checks++;
    if (zone_state[5:4] !== 2'd3) begin
      failures++;
      $display("FAIL clr_ign got=%0d exp=3", zone_state[5:4]);
    end
    send(2, 12'd3000, 1'b1);
    checks++;
    if (zone_state[5:4] !== 2'd3) begin
      failures++;
      $display("FAIL sticky got=%0d exp=3", zone_state[5:4]);
    end
    pulse_clear();
    checks++;
    if (zone_state[5:4] !== 2'd2 || any_emergency !== 1'b0) begin
      failures++;
      $display("FAIL clr got=%0d/%b exp=2/0",
               zone_state[5:4], any_emergency);
    end
  endtask

  task automatic test_hysteresis();
    repeat (4) send(1, 12'd2500, 1'b0);
    checks++;
    if (zone_state[3:2] !== 2'd1) begin
      failures++;
      $display("FAIL z1_warm got=%0d exp=1", zone_state[3:2]);
    end
    send(1, 12'd1900, 1'b1);
    repeat (9) send(1, 12'd1900, 1'b0);
    checks++;
    if (zone_state[3:2] !== 2'd1) begin
      failures++;
      $display("FAIL hyst_hold got=%0d exp=1", zone_state[3:2]);
    end
    send(1, 12'd1700, 1'b1);
    repeat (2) send(1, 12'd1700, 1'b0);
    checks++;
    if (zone_state[3:2] !== 2'd1) begin
      failures++;
      $display("FAIL hyst_3 got=%0d exp=1", zone_state[3:2]);
    end
    send(1, 12'd1700, 1'b0);
    checks++;
    if (zone_state[3:2] !== 2'd0) begin
      failures++;
      $display("FAIL hyst_cool got=%0d exp=0", zone_state[3:2]);
    end
  endtask

  task automatic test_hottest();
    @(negedge clk);
    temp_in = {12'd500, 12'd3000, 12'd3000, 12'd1000};
    temp_valid = 4'b1111;
    om_pulse = 1'b1;
    @(negedge clk);
    temp_valid = '0;
    om_pulse = 1'b0;
    @(negedge clk);
    checks++;
    if (hottest_zone !== 2'd1 || hottest_temp !== 12'd3000) begin
      failures++;
      $display("FAIL tie got=%0d/%0d exp=1/3000",
               hottest_zone, hottest_temp);
    end
    send(3, 12'd4000, 1'b1);
    checks++;
    if (hottest_zone !== 2'd3 || hottest_temp !== 12'd4000) begin
      failures++;
      $display("FAIL om_load got=%0d/%0d exp=3/4000",
               hottest_zone, hottest_temp);
    end
    checks++;
    if (emergency !== 4'b1000 || any_emergency !== 1'b1) begin
      failures++;
      $display("FAIL z3_crit got=%b/%b exp=1000/1",
               emergency, any_emergency);
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (zone_state !== 8'h00 || any_emergency !== 1'b0 ||
        hottest_temp !== 12'd0) begin
      failures++;
      $display("FAIL mid_rst got=%h/%b/%0d exp=00/0/0",
               zone_state, any_emergency, hottest_temp);
    end
    @(negedge clk);
    rst_n = 1'b1;
    send(0, 12'd2500, 1'b0);
    checks++;
    if (hottest_temp !== 12'd2500) begin
      failures++;
      $display("FAIL unprime got=%0d exp=2500", hottest_temp);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    @(negedge clk);
    temp_in[23:12] = 12'd3000;
    temp_valid = 4'b0010;
    repeat (4) @(negedge clk);
    temp_valid = '0;
    checks++;
    if (zone_state[3:2] !== 2'd0) begin
      failures++;
      $display("FAIL b2b_early got=%0d exp=0", zone_state[3:2]);
    end
    @(negedge clk);
    checks++;
    if (zone_state[3:2] !== 2'd1 || waveguide_en !== 4'b0010) begin
      failures++;
      $display("FAIL b2b_warm got=%0d/%b exp=1/0010",
               zone_state[3:2], waveguide_en);
    end
  endtask

  task automatic test_trend();
    do_reset();
    repeat (4) send(0, 12'd3000, 1'b0);
    repeat (3) send(0, 12'd3600, 1'b0);
    checks++;
`ifdef THERMAL_GOV_TREND_EN
    if (trend_up !== 4'b0001) begin
      failures++;
      $display("FAIL trend_up got=%b exp=0001", trend_up);
    end
`else
    if (trend_up !== 4'b0000) begin
      failures++;
      $display("FAIL trend_off got=%b exp=0000", trend_up);
    end
`endif
    repeat (11) send(0, 12'd3600, 1'b0);
    checks++;
`ifdef THERMAL_GOV_TREND_EN
    if (zone_state[1:0] !== 2'd2) begin
      failures++;
      $display("FAIL trend_fast got=%0d exp=2", zone_state[1:0]);
    end
`else
    if (zone_state[1:0] !== 2'd1) begin
      failures++;
      $display("FAIL trend_slow got=%0d exp=1", zone_state[1:0]);
    end
    repeat (3) send(0, 12'd3600, 1'b0);
    checks++;
    if (zone_state[1:0] !== 2'd2) begin
      failures++;
      $display("FAIL trend_dwell got=%0d exp=2", zone_state[1:0]);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_warm_entry();
    test_dwell();
    test_crit();
    test_hysteresis();
    test_hottest();
    test_mid_reset();
    test_back_to_back();
    test_trend();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/thermal_governor_mz.md
Name: thermal_governor_mz

Overview:
Multi-zone thermal governor. It is the parametrised successor to the single-zone thermal FSM, generalised to N zones, any sensor width and runtime-programmable thresholds. Each zone gets:
- EMA filtering
- dwell-qualified escalation and de-escalation with hysteresis
- a sticky emergency that only software can clear
The block also reports the hottest zone. It sits between the on-chip sensor array and the phononic waveguide, harvester and clock-throttle logic.

Parameters:
NUM_ZONES, 4, number of independent zones (1..16)
TEMP_W, 12, sensor/average width in bits
AVG_SHIFT, 3, EMA weight 1/2^AVG_SHIFT (0 = no filtering)
DWELL, 4, consecutive qualifying updates required for a state change (>=1)
HYST, 200, de-escalation hysteresis in sensor units

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
temp_in  in  NUM_ZONES*TEMP_W  zone z sample at [z*TEMP_W +: TEMP_W]
temp_valid  in  NUM_ZONES  per-zone sample strobe
thr_warm  in  TEMP_W  WARM threshold
thr_hot  in  TEMP_W  HOT threshold
thr_crit  in  TEMP_W  CRIT threshold
om_pulse  in  1  resync: reprime all averages
emerg_clear  in  1  software release of latched emergencies
zone_state  out  2*NUM_ZONES  per zone 0=COOL 1=WARM 2=HOT 3=CRIT
waveguide_en  out  NUM_ZONES  state!=COOL
throttle  out  NUM_ZONES  state>=HOT
emergency  out  NUM_ZONES  state==CRIT
any_emergency  out  1  OR of emergency
hottest_zone  out  max(1,$clog2(NUM_ZONES))  index of highest average
hottest_temp  out  TEMP_W  that average
trend_up  out  NUM_ZONES  see Optional Feature (0 when disabled)

Behaviour:
- Reset: the following all go to 0 and every zone is COOL.
  - Registers: avg, primed, dwell counters.
  - Outputs: zone_state, waveguide_en, throttle, emergency, any_emergency, hottest_zone, hottest_temp, trend_up.
- EMA, on temp_valid[z] at cycle N, avg[z] is updated in cycle N+1:
  - primed=0: avg loads the raw sample and primed is set.
  - primed=1: avg <= avg + (signed(sample-avg) >>> AVG_SHIFT), computed in TEMP_W+1 signed bits and clamped to [0, 2^TEMP_W-1].
- om_pulse: clears primed and both dwell counters in every zone; state is unchanged.
  - om_pulse and temp_valid[z] in the same cycle: the sample is loaded raw and primed=1. om_pulse wins over the EMA.
- Thresholds: compare is unsigned. Lowering edges are thr_x minus HYST, saturating at 0. Bench only programs thr_warm < thr_hot < thr_crit.
- FSM evaluation: one evaluation per avg update (update strobe = temp_valid delayed one cycle). State and all outputs are registered together and change in cycle N+2.
  - Escalate (COOL->WARM on avg>=thr_warm, WARM->HOT on avg>=thr_hot): one step at a time. up_cnt counts consecutive qualifying updates; the transition happens when up_cnt reaches DWELL. A non-qualifying update zeroes up_cnt.
  - De-escalate (HOT->WARM on avg<thr_hot-HYST, WARM->COOL on avg<thr_warm-HYST): same scheme with dn_cnt.
  - CRIT entry: from any state on a single update with avg>=thr_crit. No dwell.
  - CRIT exit: only when emerg_clear=1 and avg<thr_hot, evaluated every cycle whether or not an update occurs. Goes to HOT. emerg_clear with avg>=thr_hot is ignored.
  - Both counters clear on every state change. Counters saturate at DWELL.
- Hottest-zone logic:
  - Max over all avg values, registered in the cycle after avg changes.
  - Ties go to the lowest index.
  - Unprimed zones are treated as 0.
- Reset asserted mid-operation: everything returns immediately to the reset values, including a latched CRIT.

Optional Feature:
Macro THERMAL_GOV_TREND_EN.
- Defined: per zone, a 2-bit run counter tracks updates where avg strictly increased.
  - trend_up[z]=1 after 3 consecutive rising updates; it clears on any non-rising update or on om_pulse.
  - While trend_up[z]=1, WARM->HOT escalation needs a single qualifying update instead of DWELL.
- Undefined: no trend logic is built, trend_up is tied 0, and all escalation uses DWELL.

Test Plan:
1. Reset, then thresholds 2000/3500/4000 and zone0 valid=3000 for 4 updates -> avg=3000 on the first update; zone_state[1:0]=WARM exactly 2 cycles after the 4th valid; waveguide_en=0001.
2. Zone0 WARM, samples of 3600 (primed, SHIFT=3): the avg ramps and crosses 3500 -> HOT only after 4 consecutive updates >=3500; an interleaved update below 3500 restarts the count.
3. Zone2 HOT, one sample driving avg>=4000 after an om_pulse-primed load of 4095 -> CRIT next update; emergency[2]=1 and any_emergency=1. Then avg=3000 without emerg_clear -> stays CRIT. Assert emerg_clear -> HOT.
4. Hysteresis: zone1 WARM, avg=1900 for 10 updates -> stays WARM. avg=1700 for 4 updates -> COOL.
5. Zones with avgs 1000/3000/3000/500 -> hottest_zone=1, hottest_temp=3000. om_pulse together with zone3 valid=4000 -> zone3 avg=4000 immediately and hottest_zone=3.
6. THERMAL_GOV_TREND_EN: zone0 WARM with rising samples 3100, 3300, 3520 -> trend_up[0]=1; HOT on the first update >=3500. The same stimulus with the macro undefined needs 4 updates.
